issue_div_fifo: RTL and testbench

ISSUE_DIV_FIFO -- requirements
Module: issue_div_fifo

---
 rtl/issue_div_fifo.sv | 116 +++++++++++
 tb/tb_issue_div_fifo.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_div_fifo.sv
`default_nettype none
// ============================================================================
// Module      : issue_div_fifo (with package issue_div_fifo_pkg)
// Description : Small first-word-fall-through FIFO between the issue stage and
//               the iterative divider. Pointers carry an extra wrap bit so that
//               full and empty are told apart without a separate counter.
//               A commit-stage flush empties the queue in one cycle.
// Ports       : clk, rst                       - clock, sync active-high reset
//               issue_div_fifo_data_in/_push   - write side (issue stage)
//               issue_div_fifo_full/_count     - occupancy status
//               issue_div_fifo_data_out/_valid - head entry (fall-through)
//               issue_div_fifo_pop             - read side (divider)
//               commit_feedback_pack           - flush from commit stage
// Revision    : 1.0 - initial release
// ============================================================================

package issue_div_fifo_pkg;

    // Operation handed from issue to the divider.
    typedef struct packed {
        logic        valid;
        logic [6:0]  rob_id;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
    } issue_execute_pack_t;

    // Commit-stage feedback; only the flush request matters here.
    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

endpackage

module issue_div_fifo
    import issue_div_fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  issue_execute_pack_t           issue_div_fifo_data_in,
    input  logic                          issue_div_fifo_push,
    output logic                          issue_div_fifo_full,
    output logic [$clog2(DEPTH):0]        issue_div_fifo_count,
    output issue_execute_pack_t           issue_div_fifo_data_out,
    output logic                          issue_div_fifo_data_out_valid,
    input  logic                          issue_div_fifo_pop,
    input  commit_feedback_pack_t         commit_feedback_pack
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    // Storage is deliberately not reset: the pointers alone define content.
    issue_execute_pack_t r_mem [DEPTH];

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;

    logic               w_flush;
    logic               w_empty;
    logic               w_full;
    logic               w_push_acc;
    logic               w_pop_acc;
    logic [c_IDX_W-1:0] w_widx;
    logic [c_IDX_W-1:0] w_ridx;

    assign w_widx  = r_wptr[c_IDX_W-1:0];
    assign w_ridx  = r_rptr[c_IDX_W-1:0];
    assign w_flush = commit_feedback_pack.enable & commit_feedback_pack.flush;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_widx == w_ridx) && (r_wptr[c_IDX_W] != r_rptr[c_IDX_W]);

    // Acceptance uses the registered full/empty state, so a pop in the same
    // cycle never frees room for a push, and a push into an empty queue is
    // not poppable until the following cycle.
    assign w_push_acc = issue_div_fifo_push & ~w_full  & ~w_flush;
    assign w_pop_acc  = issue_div_fifo_pop  & ~w_empty & ~w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc && !rst) begin
            r_mem[w_widx] <= issue_div_fifo_data_in;
        end
    end

    // All outputs depend on registered pointers only.
    assign issue_div_fifo_full           = w_full;
    assign issue_div_fifo_count          = r_wptr - r_rptr;
    assign issue_div_fifo_data_out_valid = ~w_empty;
    assign issue_div_fifo_data_out       = w_empty ? '0 : r_mem[w_ridx];

endmodule

`default_nettype wire

// File: tb/tb_issue_div_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_div_fifo
// Description : Self-checking bench for issue_div_fifo. A queue-based model
//               tracks the expected contents; scenario tasks run in sequence.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_issue_div_fifo;
    import issue_div_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    issue_execute_pack_t   din;
    logic                  push;
    logic                  full;
    logic [CW-1:0]         count;
    issue_execute_pack_t   dout;
    logic                  dvalid;
    logic                  pop;
    commit_feedback_pack_t fb;

    int checks = 0;
    int errors = 0;

    issue_execute_pack_t q[$];

    always #5 clk = ~clk;

    issue_div_fifo #(.DEPTH(DEPTH)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .issue_div_fifo_data_in        (din),
        .issue_div_fifo_push           (push),
        .issue_div_fifo_full           (full),
        .issue_div_fifo_count          (count),
        .issue_div_fifo_data_out       (dout),
        .issue_div_fifo_data_out_valid (dvalid),
        .issue_div_fifo_pop            (pop),
        .commit_feedback_pack          (fb)
    );

    function automatic issue_execute_pack_t rand_pack();
        issue_execute_pack_t p;
        p.valid     = 1'b1;
        p.rob_id    = 7'($urandom);
        p.rd        = 5'($urandom);
        p.op        = 4'($urandom);
        p.rs1_value = $urandom;
        p.rs2_value = $urandom;
        return p;
    endfunction

    // Advance one clock; the model applies the queue rules to the inputs
    // presented during this cycle.
    task automatic step();
        bit                  fl;
        bit                  push_ok;
        bit                  pop_ok;
        issue_execute_pack_t d;
        fl      = fb.enable && fb.flush;
        push_ok = push && (q.size() < DEPTH) && !fl;
        pop_ok  = pop && (q.size() > 0) && !fl;
        d       = din;
        @(posedge clk);
        #1;
        if (rst || fl) begin
            q.delete();
        end else begin
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
    endtask

    task automatic idle_inputs();
        push = 1'b0;
        pop  = 1'b0;
        fb   = '0;
        rst  = 1'b0;
        din  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst  = 1'b1;
        push = 1'b1;
        pop  = 1'b1;
        din  = rand_pack();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== '0 || full !== 1'b0 || dvalid !== 1'b0 || dout !== '0) begin
                errors++;
                $display("FAIL reset cyc%0d: count=%0d full=%0b valid=%0b dout=%h, required 0/0/0/0",
                         i, count, full, dvalid, dout);
            end
        end
        idle_inputs();
    endtask

    task automatic test_fill(output issue_execute_pack_t a);
        issue_execute_pack_t first;
        first = '0;
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1;
            din  = rand_pack();
            if (i == 0) first = din;
            step();
            checks++;
            if (count !== CW'(i + 1)) begin
                errors++;
                $display("FAIL fill_count push%0d: got %0d required %0d", i, count, i + 1);
            end
        end
        push = 1'b0;
        a = first;
        checks++;
        if (full !== 1'b1 || dvalid !== 1'b1 || dout !== first) begin
            errors++;
            $display("FAIL fill_state: full=%0b valid=%0b dout=%h, required 1/1/%h",
                     full, dvalid, dout, first);
        end
    endtask

    task automatic test_full_push_pop();
        issue_execute_pack_t exp_head;
        push = 1'b1;
        pop  = 1'b1;
        din  = rand_pack();
        step();
        push = 1'b0;
        checks++;
        if (count !== CW'(3) || full !== 1'b0 || dout !== q[0]) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d full=%0b dout=%h, required 3/0/%h",
                     count, full, dout, q[0]);
        end
        for (int i = 0; i < 3; i++) begin
            exp_head = q[0];
            checks++;
            if (dvalid !== 1'b1 || dout !== exp_head) begin
                errors++;
                $display("FAIL drain%0d: valid=%0b dout=%h, required 1/%h", i, dvalid, dout, exp_head);
            end
            step();
        end
        pop = 1'b0;
        checks++;
        if (dvalid !== 1'b0 || count !== '0 || dout !== '0) begin
            errors++;
            $display("FAIL drained: valid=%0b count=%0d dout=%h, required 0/0/0", dvalid, count, dout);
        end
    endtask

    task automatic test_empty_push_pop();
        issue_execute_pack_t x;
        x    = rand_pack();
        din  = x;
        push = 1'b1;
        pop  = 1'b1;
        step();
        push = 1'b0;
        pop  = 1'b0;
        checks++;
        if (dvalid !== 1'b1 || dout !== x || count !== CW'(1)) begin
            errors++;
            $display("FAIL empty_push_pop: valid=%0b dout=%h count=%0d, required 1/%h/1",
                     dvalid, dout, count, x);
        end
    endtask

    task automatic test_steady();
        issue_execute_pack_t exp_head;
        push = 1'b1;
        pop  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_head = q[0];
            checks++;
            if (dout !== exp_head || dvalid !== 1'b1) begin
                errors++;
                $display("FAIL steady_head%0d: dout=%h valid=%0b, required %h/1", i, dout, dvalid, exp_head);
            end
            din = rand_pack();
            step();
            checks++;
            if (count !== CW'(1)) begin
                errors++;
                $display("FAIL steady_count%0d: got %0d required 1", i, count);
            end
        end
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic test_flush();
        push = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din = rand_pack();
            step();
        end
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL pre_flush_count: got %0d required 3", count);
        end
        pop       = 1'b1;
        din       = rand_pack();
        fb.enable = 1'b1;
        fb.flush  = 1'b1;
        step();
        fb   = '0;
        pop  = 1'b0;
        push = 1'b0;
        checks++;
        if (count !== '0 || dvalid !== 1'b0 || dout !== '0) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%0b dout=%h, required 0/0/0", count, dvalid, dout);
        end
        // A flush bit without enable must be ignored.
        fb.flush = 1'b1;
        push     = 1'b1;
        din      = rand_pack();
        step();
        fb   = '0;
        push = 1'b0;
        checks++;
        if (count !== CW'(1) || dout !== q[0]) begin
            errors++;
            $display("FAIL flush_no_enable: count=%0d dout=%h, required 1/%h", count, dout, q[0]);
        end
    endtask

    task automatic test_reset_mid();
        issue_execute_pack_t y;
        push = 1'b1;
        din  = rand_pack();
        step();
        checks++;
        if (count !== CW'(2)) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d required 2", count);
        end
        rst = 1'b1;
        din = rand_pack();
        step();
        rst  = 1'b0;
        push = 1'b0;
        checks++;
        if (count !== '0 || full !== 1'b0 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d full=%0b valid=%0b, required 0/0/0", count, full, dvalid);
        end
        y    = rand_pack();
        din  = y;
        push = 1'b1;
        step();
        push = 1'b0;
        checks++;
        if (dut.r_mem[0] !== y || dout !== y) begin
            errors++;
            $display("FAIL reset_push_index0: mem0=%h dout=%h, required %h", dut.r_mem[0], dout, y);
        end
    endtask

    task automatic test_random();
        issue_execute_pack_t exp_dout;
        for (int i = 0; i < 400; i++) begin
            push      = ($urandom_range(0, 3) != 0);
            pop       = ($urandom_range(0, 2) != 0);
            din       = rand_pack();
            fb.enable = ($urandom_range(0, 24) == 0);
            fb.flush  = ($urandom_range(0, 1) == 0);
            rst       = ($urandom_range(0, 79) == 0);
            step();
            exp_dout = (q.size() > 0) ? q[0] : '0;
            checks++;
            if (count !== CW'(q.size()) || full !== (q.size() == DEPTH) ||
                dvalid !== (q.size() > 0) || dout !== exp_dout) begin
                errors++;
                $display("FAIL random%0d: count=%0d full=%0b valid=%0b dout=%h, required %0d/%0b/%0b/%h",
                         i, count, full, dvalid, dout, q.size(), (q.size() == DEPTH),
                         (q.size() > 0), exp_dout);
            end
        end
        idle_inputs();
    endtask

    issue_execute_pack_t first_a;

    initial begin
        idle_inputs();
        test_reset();
        test_fill(first_a);
        test_full_push_pop();
        test_empty_push_pop();
        test_steady();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
